dot_product_accumulator: RTL



---
 rtl/dot_pkg.sv | 15 +
 rtl/sum4_pipe.sv | 39 +++
 rtl/dot_product_accumulator.sv | 108 ++++++++++
 3 files changed

// File: rtl/dot_pkg.sv
// Shared defaults, FSM encoding and saturation constant for the dot-product accumulator.
package dot_pkg;
  localparam int DOT_PROD_W = 16;
  localparam int DOT_LEN_W  = 8;
  localparam int DOT_ACC_W  = 32;

  localparam logic [DOT_ACC_W-1:0] ACC_MAX = '1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;
endpackage

// File: rtl/sum4_pipe.sv
// Two-stage registered four-input adder tree with valid propagation.
// Stage 1 forms two pair sums, stage 2 their total; busy_o covers both stages.
module sum4_pipe #(
  parameter int PROD_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   valid_i,
  input  logic [3:0][PROD_W-1:0] prod_i,
  output logic [PROD_W+1:0]      sum_o,
  output logic                   valid_o,
  output logic                   busy_o
);
  localparam int STAGES = 2;

  logic [1:0][PROD_W:0] pair_d, pair_q;
  logic [PROD_W+1:0]    sum_q;
  logic [STAGES:1]      vld_pipe_q;

  for (genvar g = 0; g < 2; g++) begin : g_pair
    assign pair_d[g] = {1'b0, prod_i[2*g]} + {1'b0, prod_i[2*g+1]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pair_q     <= '0;
      sum_q      <= '0;
      vld_pipe_q <= '0;
    end else begin
      vld_pipe_q <= {vld_pipe_q[STAGES-1:1], valid_i};
      if (valid_i)       pair_q <= pair_d;
      if (vld_pipe_q[1]) sum_q  <= {1'b0, pair_q[0]} + {1'b0, pair_q[1]};
    end
  end

  assign sum_o   = sum_q;
  assign valid_o = vld_pipe_q[STAGES];
  assign busy_o  = |vld_pipe_q;
endmodule

// File: rtl/dot_product_accumulator.sv
// Pipelined dot-product engine: accumulates len beats of four lane products.
// Define DOT_SAT_EN to clamp the accumulator at all-ones on overflow instead of wrapping.
module dot_product_accumulator
  import dot_pkg::*;
#(
  parameter int PROD_W = DOT_PROD_W,
  parameter int LEN_W  = DOT_LEN_W,
  parameter int ACC_W  = DOT_ACC_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [LEN_W-1:0]  len,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PROD_W-1:0] result1,
  input  logic [PROD_W-1:0] result2,
  input  logic [PROD_W-1:0] result3,
  input  logic [PROD_W-1:0] result4,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  dot_out,
  output logic              busy,
  output logic              overflow
);
  state_e             state_q, state_d;
  logic [LEN_W-1:0]   cnt_q, cnt_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic               ovf_q, ovf_d;
  logic [ACC_W:0]     acc_sum;
  logic [PROD_W+1:0]  beat_sum;
  logic               beat_vld, pipe_busy, fire;

  assign in_ready = (state_q == ACCUM) && (cnt_q != '0);
  assign fire     = in_valid && in_ready;

  sum4_pipe #(.PROD_W(PROD_W)) u_sum4 (
    .clk     (clk),
    .rst     (rst),
    .valid_i (fire),
    .prod_i  ({result4, result3, result2, result1}),
    .sum_o   (beat_sum),
    .valid_o (beat_vld),
    .busy_o  (pipe_busy)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    ovf_d   = ovf_q;
    acc_sum = {1'b0, acc_q} + {{(ACC_W-PROD_W-1){1'b0}}, beat_sum};

    if (beat_vld && (state_q == ACCUM || state_q == DRAIN)) begin
      acc_d = acc_sum[ACC_W-1:0];
      if (acc_sum[ACC_W]) begin
        ovf_d = 1'b1;
`ifdef DOT_SAT_EN
        acc_d = '1;
`endif
      end
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          acc_d = '0;
          ovf_d = 1'b0;
          if (len != '0) begin
            cnt_d   = len;
            state_d = ACCUM;
          end else begin
            state_d = DONE;
          end
        end
      end
      ACCUM: begin
        if (fire) begin
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == LEN_W'(1)) state_d = DRAIN;
        end
      end
      // Completion is timed by the adder-tree valid bits, not a fixed delay.
      DRAIN:   if (!pipe_busy) state_d = DONE;
      DONE:    if (out_ready)  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign out_valid = (state_q == DONE);
  assign dot_out   = acc_q;
  assign busy      = (state_q != IDLE);
  assign overflow  = ovf_q;
endmodule
